// File: rtl/bookkeeping_directory_param.sv
// MSI bookkeeping directory: one row of {state, tag} per (core, cache type) slot per set,
// cleared by a hardware sweep after reset and served through single-outstanding put/get handshakes.
module bookkeeping_directory_param #(
    parameter int INDEX_WIDTH     = 12,
    parameter int TAG_WIDTH       = 18,
    parameter int STATE_WIDTH     = 2,
    parameter int NUM_CORES       = 2,
    parameter int NUM_CACHE_TYPES = 2,
    localparam int NUM_SETS = 1 << INDEX_WIDTH,
    localparam int ROW      = STATE_WIDTH + TAG_WIDTH,
    localparam int SLOTS    = NUM_CORES * NUM_CACHE_TYPES,
    localparam int CID_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int CT_W     = (NUM_CACHE_TYPES > 1) ? $clog2(NUM_CACHE_TYPES) : 1,
    localparam int REQ_W    = INDEX_WIDTH + 1 + ROW + CID_W + CT_W,
    localparam int ENTRY_W  = SLOTS * ROW
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               put_valid,
    output logic               put_ready,
    input  logic [REQ_W-1:0]   put_request,
    input  logic               get_valid,
    output logic               get_ready,
    output logic [ENTRY_W-1:0] get_response,
    output logic               init_done,
    output logic               bad_slot
);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [INDEX_WIDTH-1:0] clear_ptr_r;
    logic                   init_done_r;
    logic                   bad_slot_r;
    logic                   has_request_r;
    logic [REQ_W-1:0]       last_request_r;
    logic [ENTRY_W-1:0]     mem_r [NUM_SETS];

    logic [INDEX_WIDTH-1:0] last_idx_s;
    logic                   last_wv_s;
    logic [ROW-1:0]         last_row_s;
    logic [CID_W-1:0]       last_core_s;
    logic [CT_W-1:0]        last_ct_s;
    logic [31:0]            core_ext_s;
    logic [31:0]            ct_ext_s;
    logic [31:0]            slot_s;
    logic                   slot_valid_s;
    logic [ENTRY_W-1:0]     rd_entry_s;
    logic [ENTRY_W-1:0]     wr_entry_s;
    logic                   sweep_last_s;
    logic                   commit_s;
    logic                   put_fire_s;
    logic                   get_fire_s;
    logic                   has_request_next_s;

    assign last_ct_s    = last_request_r[CT_W-1:0];
    assign last_core_s  = last_request_r[CT_W +: CID_W];
    assign last_row_s   = last_request_r[CT_W + CID_W +: ROW];
    assign last_wv_s    = last_request_r[CT_W + CID_W + ROW];
    assign last_idx_s   = last_request_r[REQ_W-1 -: INDEX_WIDTH];
    assign rd_entry_s   = mem_r[last_idx_s];
    assign sweep_last_s = (clear_ptr_r == {INDEX_WIDTH{1'b1}});

    assign get_response = rd_entry_s;
    assign init_done    = init_done_r;
    assign bad_slot     = bad_slot_r;

    // Slot decode and read-modify-write merge; slot 0 lives in the MSBs of the entry.
    always_comb begin
        core_ext_s   = 32'(last_core_s);
        ct_ext_s     = 32'(last_ct_s);
        slot_valid_s = (core_ext_s < 32'(NUM_CORES)) && (ct_ext_s < 32'(NUM_CACHE_TYPES));
        slot_s       = core_ext_s * 32'(NUM_CACHE_TYPES) + ct_ext_s;
        wr_entry_s   = rd_entry_s;
        if (slot_valid_s) begin
            wr_entry_s[(32'(SLOTS) - 32'd1 - slot_s) * 32'(ROW) +: ROW] = last_row_s;
        end else begin
            wr_entry_s = rd_entry_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (sweep_last_s) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = ST_CLEAR;
        endcase
    end

    // FSM outputs and handshake decode; both readies are held low during reset.
    always_comb begin
        put_ready = 1'b0;
        get_ready = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_READY: begin
                put_ready = RST_N && (!has_request_r || last_wv_s || get_valid);
                get_ready = RST_N && has_request_r && !last_wv_s;
                commit_s  = RST_N && has_request_r && last_wv_s;
            end
            ST_CLEAR: begin
                put_ready = 1'b0;
                get_ready = 1'b0;
                commit_s  = 1'b0;
            end
            default: begin
                put_ready = 1'b0;
                get_ready = 1'b0;
                commit_s  = 1'b0;
            end
        endcase
        put_fire_s         = put_valid && put_ready;
        get_fire_s         = get_valid && get_ready;
        has_request_next_s = put_fire_s || (has_request_r && !get_fire_s && !last_wv_s);
    end

    // Directory storage: sweep and commits are exclusive by FSM state, so one write port suffices.
    always_ff @(posedge CLK) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clear_ptr_r] <= {ENTRY_W{1'b0}};
        end else if (commit_s && slot_valid_s) begin
            mem_r[last_idx_s] <= wr_entry_s;
        end
    end

    // Sweep pointer, status flags and the latched request.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clear_ptr_r    <= {INDEX_WIDTH{1'b0}};
            init_done_r    <= 1'b0;
            bad_slot_r     <= 1'b0;
            has_request_r  <= 1'b0;
            last_request_r <= {REQ_W{1'b0}};
        end else begin
            if (state_r == ST_CLEAR) begin
                clear_ptr_r <= clear_ptr_r + INDEX_WIDTH'(1);
                if (sweep_last_s) begin
                    init_done_r <= 1'b1;
                end
            end
            if (commit_s && !slot_valid_s) begin
                bad_slot_r <= 1'b1;
            end
            has_request_r <= has_request_next_s;
            if (put_fire_s) begin
                last_request_r <= put_request;
            end
        end
    end

endmodule

// File: tb/tb_bookkeeping_directory_param.sv
// Directed bench for bookkeeping_directory_param: default 2x2 instance plus a 3-core instance
// with a small set count for out-of-range slot writes.
module tb_bookkeeping_directory_param;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    // Default instance: REQ_W = 35, ENTRY_W = 80.
    logic        put_valid = 1'b0;
    logic        put_ready;
    logic [34:0] put_request = '0;
    logic        get_valid = 1'b0;
    logic        get_ready;
    logic [79:0] get_response;
    logic        init_done;
    logic        bad_slot;

    // Three-core instance: INDEX_WIDTH = 4, REQ_W = 28, ENTRY_W = 120.
    logic         p2_valid = 1'b0;
    logic         p2_ready;
    logic [27:0]  p2_request = '0;
    logic         g2_valid = 1'b0;
    logic         g2_ready;
    logic [119:0] g2_response;
    logic         init2;
    logic         bad2;

    int checks = 0;
    int errors = 0;

    bookkeeping_directory_param dut (
        .CLK(CLK), .RST_N(RST_N),
        .put_valid(put_valid), .put_ready(put_ready), .put_request(put_request),
        .get_valid(get_valid), .get_ready(get_ready), .get_response(get_response),
        .init_done(init_done), .bad_slot(bad_slot)
    );

    bookkeeping_directory_param #(.INDEX_WIDTH(4), .NUM_CORES(3), .NUM_CACHE_TYPES(2)) dut3 (
        .CLK(CLK), .RST_N(RST_N),
        .put_valid(p2_valid), .put_ready(p2_ready), .put_request(p2_request),
        .get_valid(g2_valid), .get_ready(g2_ready), .get_response(g2_response),
        .init_done(init2), .bad_slot(bad2)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put1(input logic [11:0] idx, input logic wv, input logic [19:0] row,
                        input logic core, input logic ct);
        int n;
        put_request = {idx, wv, row, core, ct};
        put_valid   = 1'b1;
        n = 0;
        while (!put_ready && n < 20) begin
            tick();
            n++;
        end
        if (!put_ready) chk("put1_timeout", 128'd0, 128'd1);
        tick();
        put_valid = 1'b0;
    endtask

    task automatic rd1(input logic [11:0] idx, input logic [79:0] exp, input string tag);
        put1(idx, 1'b0, 20'h0, 1'b0, 1'b0);
        chk({tag, "_gr"}, 128'(get_ready), 128'd1);
        chk(tag, 128'(get_response), 128'(exp));
        get_valid = 1'b1;
        tick();
        get_valid = 1'b0;
    endtask

    task automatic put2(input logic [3:0] idx, input logic wv, input logic [19:0] row,
                        input logic [1:0] core, input logic ct);
        int n;
        p2_request = {idx, wv, row, core, ct};
        p2_valid   = 1'b1;
        n = 0;
        while (!p2_ready && n < 20) begin
            tick();
            n++;
        end
        if (!p2_ready) chk("put2_timeout", 128'd0, 128'd1);
        tick();
        p2_valid = 1'b0;
    endtask

    task automatic rd2(input logic [3:0] idx, input logic [119:0] exp, input string tag);
        put2(idx, 1'b0, 20'h0, 2'd0, 1'b0);
        chk({tag, "_gr"}, 128'(g2_ready), 128'd1);
        chk(tag, 128'(g2_response), 128'(exp));
        g2_valid = 1'b1;
        tick();
        g2_valid = 1'b0;
    endtask

    // Counts edges from release until init_done rises; put_ready must stay low meanwhile.
    task automatic sweep(input string tag);
        int  cnt;
        logic saw_ready;
        cnt       = 0;
        saw_ready = 1'b0;
        while (!init_done && cnt < 5000) begin
            if (put_ready) saw_ready = 1'b1;
            tick();
            cnt++;
        end
        chk({tag, "_cycles"}, 128'(cnt), 128'd4096);
        chk({tag, "_ready_low"}, 128'(saw_ready), 128'd0);
    endtask

    initial begin
        // Test 1: reset, full sweep, top index reads zero.
        repeat (3) tick();
        chk("rst_put_ready", 128'(put_ready), 128'd0);
        chk("rst_init_done", 128'(init_done), 128'd0);
        chk("rst_get_ready", 128'(get_ready), 128'd0);
        RST_N = 1'b1;
        sweep("sweep1");
        chk("init3_done", 128'(init2), 128'd1);
        chk("post_sweep_put_ready", 128'(put_ready), 128'd1);
        rd1(12'hFFF, 80'h0, "rd_fff");

        // Test 2: single-slot write then read back.
        put1(12'd5, 1'b1, 20'h31234, 1'b1, 1'b0);
        rd1(12'd5, {20'h0, 20'h0, 20'h31234, 20'h0}, "rd_idx5");
        chk("bad_slot_clean", 128'(bad_slot), 128'd0);

        // Test 3: write occupies one cycle, read of same index right behind it.
        put1(12'd7, 1'b1, 20'hABCDE, 1'b1, 1'b1);
        chk("wr_put_ready", 128'(put_ready), 128'd1);
        chk("wr_get_ready", 128'(get_ready), 128'd0);
        rd1(12'd7, {20'h0, 20'h0, 20'h0, 20'hABCDE}, "rd_idx7");

        // Test 4: stalled response, then simultaneous get and put.
        put1(12'd6, 1'b1, 20'h12345, 1'b0, 1'b0);
        put1(12'd5, 1'b0, 20'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_put_ready", 128'(put_ready), 128'd0);
            chk("stall_resp", 128'(get_response), 128'({20'h0, 20'h0, 20'h31234, 20'h0}));
            tick();
        end
        put_request = {12'd6, 1'b0, 20'h0, 1'b0, 1'b0};
        put_valid   = 1'b1;
        get_valid   = 1'b1;
        #1;
        chk("both_fire_put_ready", 128'(put_ready), 128'd1);
        tick();
        put_valid = 1'b0;
        get_valid = 1'b0;
        chk("idx6_get_ready", 128'(get_ready), 128'd1);
        chk("idx6_resp", 128'(get_response), 128'({20'h12345, 20'h0, 20'h0, 20'h0}));
        get_valid = 1'b1;
        tick();
        get_valid = 1'b0;

        // Test 6: three-core instance, core 3 does not exist.
        chk("bad2_clean", 128'(bad2), 128'd0);
        put2(4'd2, 1'b1, 20'hFFFFF, 2'd3, 1'b0);
        rd2(4'd2, 120'h0, "rd2_idx2");
        chk("bad2_set", 128'(bad2), 128'd1);
        put2(4'd3, 1'b1, 20'h55555, 2'd2, 1'b1);
        rd2(4'd3, {100'h0, 20'h55555}, "rd2_idx3");
        chk("bad2_sticky", 128'(bad2), 128'd1);

        // Test 5: reset mid-sweep restarts it; prior contents are gone.
        RST_N = 1'b0;
        #1;
        chk("rst_comb_put_ready", 128'(put_ready), 128'd0);
        tick();
        RST_N = 1'b1;
        repeat (100) tick();
        chk("mid_sweep_init_done", 128'(init_done), 128'd0);
        RST_N = 1'b0;
        tick();
        chk("rst2_init_done", 128'(init_done), 128'd0);
        chk("rst2_bad2", 128'(bad2), 128'd0);
        RST_N = 1'b1;
        sweep("sweep2");
        rd1(12'd5, 80'h0, "rd_idx5_cleared");
        rd1(12'd7, 80'h0, "rd_idx7_cleared");
        rd2(4'd3, 120'h0, "rd2_idx3_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bookkeeping_directory_param.md
Name: bookkeeping_directory_param

Overview:
Parametrised MSI bookkeeping directory. It stores, for every set index, one row of {MSI state, tag} per (core, cache type) slot, and serves single-outstanding read and write requests through put/get handshakes. Compared with the fixed 2-core/2-type directory, it adds:
- generic core and cache-type counts;
- a hardware clear sweep after reset, so correctness never depends on simulator or FPGA initial values;
- detection of out-of-range slot writes.

It sits between the cache coherence controllers and the memory-side arbiter.

Parameters:
- INDEX_WIDTH, 12, set index bits; NUM_SETS = 2**INDEX_WIDTH.
- TAG_WIDTH, 18, tag bits per row.
- STATE_WIDTH, 2, MSI state bits per row.
- NUM_CORES, 2, number of cores (1..8).
- NUM_CACHE_TYPES, 2, cache types per core (type 0 = imem, type 1 = dmem).
- Derived values (not overridable):
  - ROW = STATE_WIDTH+TAG_WIDTH.
  - SLOTS = NUM_CORES*NUM_CACHE_TYPES.
  - CID_W = max(1, clog2(NUM_CORES)).
  - CT_W = max(1, clog2(NUM_CACHE_TYPES)).
  - REQ_W = INDEX_WIDTH+1+ROW+CID_W+CT_W.
  - ENTRY_W = SLOTS*ROW.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; synchronous, active-low.
- put_valid  in  1  request offered.
- put_ready  out  1  directory accepts request.
- put_request  in  REQ_W  packed, MSB first: {idx, write_valid, row, core_id, cache_type}.
- get_valid  in  1  consumer takes read response.
- get_ready  out  1  read response available.
- get_response  out  ENTRY_W  all slot rows of the requested set; slot 0 in the MSBs.
- init_done  out  1  clear sweep finished.
- bad_slot  out  1  sticky flag: a write targeted a nonexistent slot.

Behaviour:
- Reset and clock: RST_N and CLK are as stated in Ports. While RST_N=0 at a clock edge:
  - has_request, init_done and bad_slot clear to 0;
  - FSM goes to CLEAR; clear_ptr goes to 0;
  - put_ready and get_ready are forced to 0 combinationally whenever RST_N=0.
- Slot numbering: slot = core_id*NUM_CACHE_TYPES + cache_type. A slot is valid iff core_id < NUM_CORES and cache_type < NUM_CACHE_TYPES.
- FSM state CLEAR:
  - each cycle writes all-zero ENTRY_W to mem[clear_ptr], then clear_ptr increments;
  - on the cycle clear_ptr = NUM_SETS-1, after that write, go to READY and set init_done = 1;
  - total NUM_SETS cycles;
  - put_ready = 0 and get_ready = 0 throughout;
  - RST_N low mid-sweep restarts the sweep from index 0.
- FSM state READY:
  - Holds one latched request (last_request) plus a has_request flag.
  - Memory read is combinational at last_request.idx: get_response = mem[last.idx] whenever has_request.
  - Contents of get_response are don't-care when get_ready = 0.
  - get_ready = has_request && !last.write_valid.
  - put_ready = !has_request || last.write_valid || get_valid.
  - put fire = put_valid && put_ready: latches put_request into last_request. The response for a read is therefore available the cycle after acceptance.
  - Write commit: at the clock edge where has_request && last.write_valid, mem[last.idx] is rewritten with only the addressed slot replaced by last.row. All other slots are unchanged.
  - Write to an invalid slot: memory is unchanged and bad_slot is set to 1. bad_slot stays 1 until reset.
  - has_request_next = put_fire || (has_request && !get_fire && !last.write_valid). A write occupies exactly one cycle with no get handshake.
- Hazards:
  - A request accepted in the same cycle as a write commit reads after the commit, because the read is combinational from the next cycle. A read following a write to the same index therefore sees the new value; no bypass is needed.
  - get fire and put fire in the same cycle: the response is consumed and the new request latched; no bubble.
  - Response stability: while get_ready && !get_valid, last_request and mem[last.idx] must not change, and put_ready = 0.
- Only one write port to mem: the clear sweep and write commits are mutually exclusive by FSM state.

Test Plan:
1. Defaults; release RST_N at cycle 0 -> put_ready = 0 and init_done = 0 for cycles 0..4095; init_done = 1 from cycle 4096; a read of idx 0xFFF then returns 80'h0.
2. Write idx 5, core 1, type 0, row 20'h31234; then read idx 5 -> get_response = {20'h0, 20'h0, 20'h31234, 20'h0}; bad_slot = 0.
3. Write idx 7 slot 3 (20'hABCDE), accepted back-to-back with a read of idx 7 (put fires the cycle after the write is latched) -> read returns slot 3 = 20'hABCDE, and the write occupies exactly one cycle.
4. Read idx 5 with get_valid held 0 for 4 cycles -> put_ready = 0 and get_response stable; then get_valid = 1 and put_valid = 1 (read idx 6) in the same cycle -> both fire; the next cycle shows idx 6 data.
5. Pull RST_N low while clear_ptr = 100, for 1 cycle -> sweep restarts; init_done rises exactly 4096 cycles after release; earlier writes are gone (reads return 0).
6. NUM_CORES = 3, NUM_CACHE_TYPES = 2: write core_id = 3 to idx 2 -> idx 2 is unchanged (all 0); bad_slot = 1 and stays 1 across later valid writes until RST_N.
